// File: rtl/motion_system_array_pkg.sv
// Shared types and constants for the motion system array: slot map, register indices, bus FSM states.
package motion_system_array_pkg;

  localparam int SLOT_W    = 4;
  localparam int IDX_W     = 4;
  localparam int NUM_SLOTS = 16;

  localparam logic [SLOT_W-1:0] SYS_SLOT = 4'd15;

  localparam logic [IDX_W-1:0] SYS_ID_IDX     = 4'd0;
  localparam logic [IDX_W-1:0] SYS_CTRL_IDX   = 4'd1;
  localparam logic [IDX_W-1:0] SYS_STATUS_IDX = 4'd2;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_SRST_BIT  = 1;
  localparam int STATUS_ERR_BIT = 0;

  localparam logic [2:0] SRST_CYCLES = 3'd4;

  localparam logic [IDX_W-1:0] MOT_POS_IDX   = 4'd0;
  localparam logic [IDX_W-1:0] MOT_INDEX_IDX = 4'd1;
  localparam logic [IDX_W-1:0] MOT_RAW_IDX   = 4'd2;

  localparam logic [IDX_W-1:0] PWM_PERIOD_IDX = 4'd0;
  localparam logic [IDX_W-1:0] PWM_DUTY_IDX   = 4'd1;
  localparam logic [IDX_W-1:0] PWM_CNT_IDX    = 4'd2;

  typedef logic [31:0] register_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_WRITE, ST_READ_WAIT, ST_ERR, ST_ACK, ST_HOLD
  } bus_state_t;

  typedef struct packed {
    logic              wr;
    logic              rd;
    logic [SLOT_W-1:0] slot;
    logic [IDX_W-1:0]  idx;
  } bus_req_t;

  function automatic logic slot_mapped(input logic [SLOT_W-1:0] slot, input int n_units);
    return (int'(slot) < n_units) || (slot == SYS_SLOT);
  endfunction

endpackage

// File: rtl/motion_system_array_reg_bus_ctrl.sv
// Host register bus engine: latch, decode, one-cycle write strobe, delayed readback, error ack.
// Write/error ack 3 cycles after the request edge, read ack 3+READ_WAIT; held strobes are served once.
module motion_system_array_reg_bus_ctrl
  import motion_system_array_pkg::*;
#(
  parameter int NOS_UNITS  = 4,
  parameter int REG_DATA_W = 32,
  parameter int READ_WAIT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            bus_addr,
  input  logic [REG_DATA_W-1:0] bus_wdata,
  input  logic                  bus_write,
  input  logic                  bus_read,
  output logic [REG_DATA_W-1:0] bus_rdata,
  output logic                  bus_ack,
  output logic                  bus_error,
  output logic                  wr_vld,
  output logic [SLOT_W-1:0]     req_slot,
  output logic [IDX_W-1:0]      req_idx,
  output logic [REG_DATA_W-1:0] wr_dat,
  output logic                  err_vld,
  input  logic [REG_DATA_W-1:0] unit_rdata [NUM_SLOTS]
);

  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);

  bus_state_t state, state_nxt;
  bus_req_t   req;
  logic [2:0] wait_cnt;
  logic       err_q;
  logic       bad_req;

  assign bad_req = (req.wr & req.rd) | ~slot_mapped(req.slot, NOS_UNITS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req       <= '0;
      wr_dat    <= '0;
      bus_rdata <= '0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (bus_write | bus_read) begin
          req    <= '{wr: bus_write, rd: bus_read, slot: bus_addr[7:4], idx: bus_addr[3:0]};
          wr_dat <= bus_wdata;
          err_q  <= 1'b0;
        end
        ST_DECODE: begin
          wait_cnt <= '0;
          err_q    <= bad_req;
        end
        ST_READ_WAIT: begin
          if (wait_cnt == WAIT_LAST) bus_rdata <= unit_rdata[req.slot];
          else                       wait_cnt  <= wait_cnt + 3'd1;
        end
        ST_WRITE, ST_ERR: bus_rdata <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    wr_vld    = 1'b0;
    err_vld   = 1'b0;
    case (state)
      ST_IDLE:      if (bus_write | bus_read) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (bad_req)     state_nxt = ST_ERR;
        else if (req.wr) state_nxt = ST_WRITE;
        else             state_nxt = ST_READ_WAIT;
      end
      ST_WRITE: begin
        wr_vld    = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_READ_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = ST_ACK;
      ST_ERR: begin
        err_vld   = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_ACK:       state_nxt = ST_HOLD;
      // the host must drop both strobes before another request is taken
      ST_HOLD:      if (!bus_write && !bus_read) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign bus_ack   = (state == ST_ACK);
  assign bus_error = bus_ack & err_q;
  assign req_slot  = req.slot;
  assign req_idx   = req.idx;

endmodule

// File: rtl/motion_system_array.sv
// Chip-top array of quadrature motion channels and PWM channels behind one handshaked register bus.
// pwm_out follows channel state with one registered cycle; bus timing comes from the bus engine.
module motion_system_array
  import motion_system_array_pkg::*;
#(
  parameter int        NOS_MOTION = 2,
  parameter int        NOS_PWM    = 2,
  parameter int        REG_DATA_W = 32,
  parameter int        READ_WAIT  = 1,
  parameter int        PHASE_DIV  = 50,
  parameter register_t SYS_ID     = 32'h4D53_0002
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NOS_MOTION-1:0] quad_A,
  input  logic [NOS_MOTION-1:0] quad_B,
  input  logic [NOS_MOTION-1:0] quad_I,
  input  logic [7:0]            bus_addr,
  input  logic [REG_DATA_W-1:0] bus_wdata,
  input  logic                  bus_write,
  input  logic                  bus_read,
  output logic [REG_DATA_W-1:0] bus_rdata,
  output logic                  bus_ack,
  output logic                  bus_error,
  output logic [NOS_PWM-1:0]    pwm_out
);

  localparam int                    PRE_W    = $clog2(PHASE_DIV);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(PHASE_DIV - 1);
  localparam logic [REG_DATA_W-1:0] ONE      = REG_DATA_W'(1);

  logic [REG_DATA_W-1:0] unit_rdata [NUM_SLOTS];
  logic [REG_DATA_W-1:0] sys_rdata, wr_dat;
  logic [SLOT_W-1:0]     req_slot;
  logic [IDX_W-1:0]      req_idx;
  logic                  wr_vld, err_vld, sys_wr;
  logic                  gl_en, sticky_err, chan_rst, phase_tick;
  logic [2:0]            srst_cnt;
  logic [PRE_W-1:0]      prescale;
  logic [NOS_PWM-1:0]    chan_pwm;

  motion_system_array_reg_bus_ctrl #(
    .NOS_UNITS (NOS_MOTION + NOS_PWM),
    .REG_DATA_W(REG_DATA_W),
    .READ_WAIT (READ_WAIT)
  ) u_bus (
    .clk       (CLOCK_50),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_write (bus_write),
    .bus_read  (bus_read),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_error (bus_error),
    .wr_vld    (wr_vld),
    .req_slot  (req_slot),
    .req_idx   (req_idx),
    .wr_dat    (wr_dat),
    .err_vld   (err_vld),
    .unit_rdata(unit_rdata)
  );

  assign sys_wr   = wr_vld && (req_slot == SYS_SLOT);
  assign chan_rst = reset | (srst_cnt != 3'd0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      gl_en      <= 1'b0;
      sticky_err <= 1'b0;
      srst_cnt   <= '0;
      prescale   <= '0;
      phase_tick <= 1'b0;
      pwm_out    <= '0;
    end else begin
      prescale   <= (prescale == PRE_LAST) ? '0 : prescale + 1'b1;
      phase_tick <= (prescale == PRE_LAST);
      pwm_out    <= chan_pwm & {NOS_PWM{gl_en}};
      if (srst_cnt != 3'd0) srst_cnt <= srst_cnt - 3'd1;
      if (sys_wr && req_idx == SYS_CTRL_IDX) begin
        gl_en <= wr_dat[CTRL_EN_BIT];
        if (wr_dat[CTRL_SRST_BIT]) srst_cnt <= SRST_CYCLES;
      end
      if (sys_wr && req_idx == SYS_STATUS_IDX && wr_dat[STATUS_ERR_BIT]) sticky_err <= 1'b0;
      else if (err_vld)                                                  sticky_err <= 1'b1;
    end
  end

  always_comb begin
    sys_rdata = '0;
    case (req_idx)
      SYS_ID_IDX:   sys_rdata = REG_DATA_W'(SYS_ID);
      SYS_CTRL_IDX: sys_rdata[CTRL_EN_BIT] = gl_en;
      SYS_STATUS_IDX: begin
        sys_rdata[STATUS_ERR_BIT] = sticky_err;
        sys_rdata[15:8]           = 8'(NOS_MOTION);
        sys_rdata[23:16]          = 8'(NOS_PWM);
      end
      default: ;
    endcase
  end
  assign unit_rdata[NUM_SLOTS-1] = sys_rdata;

  for (genvar m = 0; m < NOS_MOTION; m++) begin : g_motion
    localparam logic [SLOT_W-1:0] SLOT = SLOT_W'(m);
    logic [2:0]            q_s1, q_s2, q_prev;  // {I, B, A}
    logic [REG_DATA_W-1:0] pos, idx_cnt, rd;
    logic                  step, up;

    // x4 decode: exactly one of A/B changed; A leading B counts up
    assign step = q_s2[0] ^ q_prev[0] ^ q_s2[1] ^ q_prev[1];
    assign up   = q_s2[0] ^ q_prev[1];

    always_ff @(posedge CLOCK_50) begin
      if (chan_rst) begin
        q_s1    <= '0;
        q_s2    <= '0;
        q_prev  <= '0;
        pos     <= '0;
        idx_cnt <= '0;
      end else begin
        q_s1   <= {quad_I[m], quad_B[m], quad_A[m]};
        q_s2   <= q_s1;
        q_prev <= q_s2;
        if (wr_vld && req_slot == SLOT && req_idx == MOT_POS_IDX) pos <= wr_dat;
        else if (step) pos <= up ? pos + ONE : pos - ONE;
        if (q_s2[2] && !q_prev[2]) idx_cnt <= idx_cnt + ONE;
      end
    end

    always_comb begin
      rd = '0;
      case (req_idx)
        MOT_POS_IDX:   rd = pos;
        MOT_INDEX_IDX: rd = idx_cnt;
        MOT_RAW_IDX:   rd = REG_DATA_W'(q_s2);
        default: ;
      endcase
    end
    assign unit_rdata[m] = rd;
  end

  for (genvar p = 0; p < NOS_PWM; p++) begin : g_pwm
    localparam logic [SLOT_W-1:0] SLOT = SLOT_W'(NOS_MOTION + p);
    logic [REG_DATA_W-1:0] period, duty, cnt, rd;

    // period and duty are in phase ticks; period 0 or 1 parks the counter at 0
    always_ff @(posedge CLOCK_50) begin
      if (chan_rst) begin
        period <= '0;
        duty   <= '0;
        cnt    <= '0;
      end else begin
        if (wr_vld && req_slot == SLOT && req_idx == PWM_PERIOD_IDX) period <= wr_dat;
        if (wr_vld && req_slot == SLOT && req_idx == PWM_DUTY_IDX)   duty   <= wr_dat;
        if (phase_tick) cnt <= (cnt + ONE >= period) ? '0 : cnt + ONE;
      end
    end

    assign chan_pwm[p] = (cnt < duty);

    always_comb begin
      rd = '0;
      case (req_idx)
        PWM_PERIOD_IDX: rd = period;
        PWM_DUTY_IDX:   rd = duty;
        PWM_CNT_IDX:    rd = cnt;
        default: ;
      endcase
    end
    assign unit_rdata[NOS_MOTION+p] = rd;
  end

  for (genvar s = NOS_MOTION + NOS_PWM; s < NUM_SLOTS - 1; s++) begin : g_unmapped
    assign unit_rdata[s] = '0;
  end

endmodule

// File: tb/tb_motion_system_array.sv
// Directed bench for motion_system_array: bus timing, system registers, errors, PWM gating, soft reset, encoder.
module tb_motion_system_array;

  localparam int NM = 2;
  localparam int NP = 2;
  localparam int RW = 1;
  localparam int PD = 50;
  // ack lands in cycle k+3 (write) / k+3+RW (read); that cycle ends at edge k+3,
  // so it is visible right after edge k+2, i.e. 2 edges after the request edge k
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 2 + RW;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] quad_A, quad_B, quad_I;
  logic [7:0]    bus_addr;
  logic [31:0]   bus_wdata, bus_rdata;
  logic          bus_write, bus_read, bus_ack, bus_error;
  logic [NP-1:0] pwm_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  motion_system_array #(
    .NOS_MOTION(NM), .NOS_PWM(NP), .REG_DATA_W(32), .READ_WAIT(RW),
    .PHASE_DIV(PD), .SYS_ID(32'h4D53_0002)
  ) dut (
    .CLOCK_50(clk), .reset(reset),
    .quad_A(quad_A), .quad_B(quad_B), .quad_I(quad_I),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write), .bus_read(bus_read),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_error(bus_error), .pwm_out(pwm_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_op(input logic wr, input logic rd, input logic [7:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdat, output logic err, output int lat);
    @(negedge clk);
    bus_addr = addr; bus_wdata = wd; bus_write = wr; bus_read = rd;
    lat = -1; rdat = 32'hDEAD_BEEF; err = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); @(negedge clk);
      if (bus_ack) begin
        lat = n; rdat = bus_rdata; err = bus_error;
        break;
      end
    end
    bus_write = 1'b0; bus_read = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d; logic e; int l;
    bus_op(1'b0, 1'b1, addr, 32'h0, d, e, l);
    chk({tag, "_lat"}, l, RD_LAT);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_e});
    chk({tag, "_data"}, d, exp_d);
  endtask

  task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] wd, input logic exp_e);
    logic [31:0] d; logic e; int l;
    bus_op(1'b1, 1'b0, addr, wd, d, e, l);
    chk({tag, "_lat"}, l, WR_LAT);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_e});
  endtask

  task automatic quad_step(input logic a, input logic b);
    @(negedge clk);
    quad_A[1] = a; quad_B[1] = b;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d; logic e; int l;
    int hi, lo, ones, acks, prev;

    reset = 1'b1; bus_addr = '0; bus_wdata = '0; bus_write = 1'b0; bus_read = 1'b0;
    quad_A = '0; quad_B = '0; quad_I = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'b0, bus_ack}, 32'd0);
    chk("rst_err", {31'b0, bus_error}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_pwm", {30'b0, pwm_out}, 32'd0);
    reset = 1'b0;

    do_read("id", 8'hF0, 32'h4D53_0002, 1'b0);
    do_read("status_dflt", 8'hF2, 32'h0002_0200, 1'b0);
    do_write("unmapped_wr", 8'h90, 32'h1234, 1'b1);
    do_read("status_sticky", 8'hF2, 32'h0002_0201, 1'b0);
    do_write("status_w1c", 8'hF2, 32'h1, 1'b0);
    do_read("status_clr", 8'hF2, 32'h0002_0200, 1'b0);

    // both strobes: error ack and the PWM period must not be written
    bus_op(1'b1, 1'b1, 8'h20, 32'h5, d, e, l);
    chk("conflict_lat", l, WR_LAT);
    chk("conflict_err", {31'b0, e}, 32'd1);
    chk("conflict_rdata", d, 32'd0);
    do_read("conflict_nowr", 8'h20, 32'd0, 1'b0);
    do_read("conflict_status", 8'hF2, 32'h0002_0201, 1'b0);
    do_write("conflict_clr", 8'hF2, 32'h1, 1'b0);
    do_read("sys_idx5", 8'hF5, 32'd0, 1'b0);

    // 50% duty on PWM slot 2 (channel 0): 4 ticks period, 2 ticks high
    do_write("pwm_period", 8'h20, 32'd4, 1'b0);
    do_write("pwm_duty", 8'h21, 32'd2, 1'b0);
    do_read("pwm_period_rb", 8'h20, 32'd4, 1'b0);
    ones = 0;
    repeat (300) begin @(negedge clk); ones += int'(pwm_out != 0); end
    chk("pwm_gated", ones, 32'd0);
    do_write("ctrl_en", 8'hF1, 32'd1, 1'b0);
    do_read("ctrl_rb", 8'hF1, 32'd1, 1'b0);
    prev = int'(pwm_out[0]); l = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (pwm_out[0] && prev == 0) begin l = n; break; end
      prev = int'(pwm_out[0]);
    end
    chk("pwm_rise_seen", {31'b0, l >= 0}, 32'd1);
    hi = 1;
    for (int n = 0; n < 400; n++) begin @(negedge clk); if (!pwm_out[0]) break; hi++; end
    lo = 1;
    for (int n = 0; n < 400; n++) begin @(negedge clk); if (pwm_out[0]) break; lo++; end
    chk("pwm_high_cycles", hi, 2 * PD);
    chk("pwm_low_cycles", lo, 2 * PD);
    chk("pwm1_idle", {31'b0, pwm_out[1]}, 32'd0);

    // soft reset: channel reset held exactly 4 cycles, one normal ack
    @(negedge clk);
    bus_addr = 8'hF1; bus_wdata = 32'd3; bus_write = 1'b1;
    hi = 0; acks = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (dut.chan_rst) hi++;
      if (bus_ack) begin acks++; bus_write = 1'b0; end
    end
    bus_write = 1'b0;
    chk("srst_cycles", hi, 32'd4);
    chk("srst_acks", acks, 32'd1);
    do_read("srst_ctrl", 8'hF1, 32'd1, 1'b0);
    do_read("srst_period", 8'h20, 32'd0, 1'b0);
    do_read("srst_duty", 8'h21, 32'd0, 1'b0);

    // encoder on motion channel 1: two forward cycles, one reverse
    repeat (2) begin
      quad_step(1'b1, 1'b0); quad_step(1'b1, 1'b1); quad_step(1'b0, 1'b1); quad_step(1'b0, 1'b0);
    end
    do_read("mot_fwd", 8'h10, 32'd8, 1'b0);
    quad_step(1'b0, 1'b1); quad_step(1'b1, 1'b1); quad_step(1'b1, 1'b0); quad_step(1'b0, 1'b0);
    do_read("mot_rev", 8'h10, 32'd4, 1'b0);
    do_read("mot0_pos", 8'h00, 32'd0, 1'b0);
    @(negedge clk); quad_I[1] = 1'b1;
    repeat (4) @(posedge clk);
    do_read("mot_raw", 8'h12, 32'd4, 1'b0);
    @(negedge clk); quad_I[1] = 1'b0;
    do_read("mot_index", 8'h11, 32'd1, 1'b0);

    // full duty with enable kept through soft reset
    do_write("pwm_period2", 8'h20, 32'd4, 1'b0);
    do_write("pwm_duty2", 8'h21, 32'd4, 1'b0);
    repeat (120) @(posedge clk);
    @(negedge clk);
    chk("pwm_full", {31'b0, pwm_out[0]}, 32'd1);

    // read held well past its ack is served once
    @(negedge clk);
    bus_addr = 8'hF0; bus_read = 1'b1; acks = 0;
    repeat (RD_LAT + 11) begin
      @(posedge clk); @(negedge clk);
      if (bus_ack) acks++;
    end
    bus_read = 1'b0;
    repeat (2) @(posedge clk);
    chk("hold_one_ack", acks, 32'd1);

    // reset while in READ_WAIT: no ack, outputs cleared
    @(negedge clk);
    bus_addr = 8'hF0; bus_read = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_ack", {31'b0, bus_ack}, 32'd0);
    chk("midrst_err", {31'b0, bus_error}, 32'd0);
    chk("midrst_rdata", bus_rdata, 32'd0);
    chk("midrst_pwm", {30'b0, pwm_out}, 32'd0);
    acks = 0;
    repeat (3) begin @(posedge clk); @(negedge clk); if (bus_ack) acks++; end
    reset = 1'b0; bus_read = 1'b0;
    repeat (6) begin @(posedge clk); @(negedge clk); if (bus_ack) acks++; end
    chk("midrst_no_ack", acks, 32'd0);
    do_read("rerequest_id", 8'hF0, 32'h4D53_0002, 1'b0);
    do_read("rerequest_ctrl", 8'hF1, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_system_array.md
Name: motion_system_array

Overview:
Parametrised successor of the two-channel motion system top level. Generates NOS_MOTION motion channels and NOS_PWM PWM channels from one clock. Adds a handshaked host register bus with address decode, per-unit readback muxing, a system register slot (ID, control, status), a global output enable and a self-clearing soft reset. Sits at chip top, between the host interface (uP/SPI bridge) and the channel instances.

Parameters:
NOS_MOTION, 2, number of motion_channel instances (1..8)
NOS_PWM, 2, number of pwm_channel instances (1..7, NOS_MOTION+NOS_PWM <= 15)
REG_DATA_W, 32, register data width
READ_WAIT, 1, extra cycles between read strobe and readback sample (0..7)
PHASE_DIV, 50, CLOCK_50 cycles per phase tick (>=2)
SYS_ID, 32'h4D53_0002, value of the read-only ID register

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
quad_A  in  NOS_MOTION  encoder A per motion channel
quad_B  in  NOS_MOTION  encoder B per motion channel
quad_I  in  NOS_MOTION  encoder index per motion channel
bus_addr  in  8  [7:4] unit slot, [3:0] register index
bus_wdata  in  REG_DATA_W  write data
bus_write  in  1  write request, level, held until bus_ack
bus_read  in  1  read request, level, held until bus_ack
bus_rdata  out  REG_DATA_W  read data, valid while bus_ack=1
bus_ack  out  1  one-cycle completion pulse
bus_error  out  1  qualifies bus_ack: unmapped slot or read+write conflict
pwm_out  out  NOS_PWM  PWM outputs, forced 0 when disabled

Behaviour:
- Reset (sync, active-high): bus_rdata=0, bus_ack=0, bus_error=0, pwm_out=0, FSM=IDLE, control=0 (outputs disabled), prescaler=0, sticky status=0; all channel resets asserted.
- Slot map: 0..NOS_MOTION-1 motion channels; NOS_MOTION..NOS_MOTION+NOS_PWM-1 PWM channels; 15 system; all other slots unmapped.
- System slot regs: idx0 ID (RO, SYS_ID); idx1 CONTROL (RW; bit0 global_enable, bit1 soft_reset self-clearing, reads 0); idx2 STATUS (bit0 sticky bus error, write-1-to-clear; bits[15:8] NOS_MOTION, [23:16] NOS_PWM). Other idx in slot 15: reads 0, writes ignored, no error.
- Bus FSM: IDLE -> DECODE -> (WRITE | READ_WAIT | ERR) -> ACK -> HOLD -> IDLE.
  - IDLE: on bus_write|bus_read at edge k, latch addr/wdata/direction.
  - DECODE (cycle k+1): slot lookup; both strobes high or unmapped slot -> ERR.
  - WRITE (k+2): one-cycle wr_strobe to selected unit with local index and data.
  - READ_WAIT: READ_WAIT+1 cycles, then unit readback registered into bus_rdata.
  - ACK: bus_ack=1 one cycle. Write ack in cycle k+3; read ack in cycle k+3+READ_WAIT; error ack in cycle k+3 with bus_error=1, bus_rdata=0, STATUS.bit0 set.
  - HOLD: wait until both strobes low, then IDLE. Requests still held after ack are never re-served.
- Channel readback: per-unit reg_out array muxed by latched slot; no shared tri-state bus.
- Phase tick: prescaler counts 0..PHASE_DIV-1; one-cycle tick when count wraps to 0; drives every pwm_channel phase enable.
- Soft reset: write CONTROL.bit1=1 -> channel reset asserted 4 cycles starting the cycle after WRITE; bus FSM, CONTROL.bit0, STATUS unaffected. Accesses to channels during the pulse are acked normally (writes lost, reads return channel reset values).
- pwm_out[i] = channel pwm & global_enable, registered (1-cycle latency).
- reset mid-transaction: FSM aborts to IDLE, no ack issued; host must re-request.

Decomposition:
- Package types: register_t (REG_DATA_W), slot/index field widths, SYS_SLOT=15, system register indices, CONTROL bit positions, FSM state enum.
- Sub-module reg_bus_ctrl: FSM, decode, strobes, readback latch, error handling. Channels built with generate loops in the top.

Test Plan:
- Reset, then read slot15 idx0 -> bus_ack at k+3+READ_WAIT, bus_rdata=0x4D530002, bus_error=0.
- Read slot15 idx2 with defaults -> rdata=0x00020200; write slot 9 -> ack with bus_error=1 at k+3, STATUS reads 0x00020201; write 1 to STATUS -> 0x00020200.
- bus_read and bus_write both high -> error ack, no wr_strobe to any unit, STATUS.bit0=1.
- Configure pwm slot 2 for 50% duty with CONTROL=0 -> pwm_out=0; write CONTROL=1 -> pwm toggles, period a multiple of PHASE_DIV ticks.
- Write CONTROL=3 -> channel resets high exactly 4 cycles, CONTROL reads 1, pwm channel registers read reset values.
- Hold bus_read 10 cycles past ack -> exactly one ack; assert reset in READ_WAIT -> no ack, all outputs 0 next cycle.
